// File: rtl/uart_fifo.sv
// uart_fifo: CPU-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor,
// sticky error flags and a level interrupt.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   uart_cs, R_W_n      chip select (one access per rising edge of cs), 1=read 0=write
//   reg_addr, data_i    register select and write data
//   data_o              read data, combinational from reg_addr
//   uart_rx, uart_tx    serial input (asynchronous), serial output (idle high)
//   irq                 registered level interrupt
module uart_fifo #(
  parameter int unsigned CLK_FRE_HZ   = 25175000,
  parameter int unsigned BAUD_DEFAULT = 115200,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned DIV_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_cs,
  input  logic       R_W_n,
  input  logic [2:0] reg_addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(CLK_FRE_HZ / BAUD_DEFAULT - 1);

  localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_DIV_LO = 3'd2, A_DIV_HI = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4, A_RX_CNT = 3'd5, A_TX_CNT = 3'd6;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  // R_BREAK holds off after a bad stop bit until the line is seen high again.
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;

  // ---------------- bus access strobe ----------------
  logic cs_d_q;
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cs_d_q <= 1'b0;
    else        cs_d_q <= uart_cs;

  logic stb, wr_stb, rd_stb;
  assign stb    = uart_cs & ~cs_d_q;
  assign wr_stb = stb & ~R_W_n;
  assign rd_stb = stb & R_W_n;

  logic tx_push, rx_pop, stat_clr, ctrl_wr, rx_flush, tx_flush;
  assign tx_push  = wr_stb && (reg_addr == A_DATA);
  assign rx_pop   = rd_stb && (reg_addr == A_DATA);
  assign stat_clr = wr_stb && (reg_addr == A_STATUS);
  assign ctrl_wr  = wr_stb && (reg_addr == A_CTRL);
  assign rx_flush = ctrl_wr & data_i[2];
  assign tx_flush = ctrl_wr & data_i[3];

  // ---------------- divisor / control ----------------
  logic [DIV_W-1:0] div_q;
  logic [15:0]      div16;
  logic             rx_ie_q, tx_ie_q;
  assign div16 = 16'(div_q);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q   <= DIV_RST;
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
    end else if (wr_stb) begin
      case (reg_addr)
        A_DIV_LO: div_q <= DIV_W'({div16[15:8], data_i});
        A_DIV_HI: div_q <= DIV_W'({data_i, div16[7:0]});
        A_CTRL:   begin rx_ie_q <= data_i[0]; tx_ie_q <= data_i[1]; end
        default:  ;
      endcase
    end

  // ---------------- FIFOs (count = wp - rp, pointers one bit wider) ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q, tx_cnt, rx_cnt;
  logic          tx_empty, tx_full, rx_empty, rx_full, tx_pop, rx_push;
  logic [7:0]    rx_shift_q;

  assign tx_cnt   = tx_wp_q - tx_rp_q;
  assign rx_cnt   = rx_wp_q - rx_rp_q;
  assign tx_empty = (tx_cnt == '0);
  assign rx_empty = (rx_cnt == '0);
  assign tx_full  = (tx_cnt == PW'(FIFO_DEPTH));
  assign rx_full  = (rx_cnt == PW'(FIFO_DEPTH));

  // NOTE: storage arrays are deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (tx_push && !tx_full) tx_mem[tx_wp_q[AW-1:0]] <= data_i;
    if (rx_push && !rx_full) rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
    end else begin
      // Flush jumps the read pointer to the write pointer and wins over any push.
      if (tx_flush) tx_rp_q <= tx_wp_q;
      else begin
        if (tx_push && !tx_full) tx_wp_q <= tx_wp_q + PW'(1);
        if (tx_pop)              tx_rp_q <= tx_rp_q + PW'(1);
      end
      if (rx_flush) rx_rp_q <= rx_wp_q;
      else begin
        if (rx_push && !rx_full)  rx_wp_q <= rx_wp_q + PW'(1);
        if (rx_pop && !rx_empty)  rx_rp_q <= rx_rp_q + PW'(1);
      end
    end

  // ---------------- TX engine ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_bit_end, tx_busy;

  // >= rather than == so a divisor lowered mid-bit cannot strand the counter.
  assign tx_bit_end = (tx_baud_q >= div_q);
  assign tx_busy    = (tx_state_q != T_IDLE) | ~tx_empty;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state_q <= T_IDLE; tx_baud_q <= '0; tx_bit_q <= '0; tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d; tx_baud_q <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;   tx_shift_q <= tx_shift_d;
    end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_bit_end ? '0 : tx_baud_q + DIV_W'(1);
    // A pop (from IDLE or at the end of STOP) starts the next frame with no idle gap.
    if (tx_pop) begin
      tx_shift_d = tx_mem[tx_rp_q[AW-1:0]];
      tx_baud_d  = '0;
      tx_state_d = T_START;
    end else begin
      unique case (tx_state_q)
        T_IDLE:  tx_baud_d = '0;
        T_START: if (tx_bit_end) begin tx_bit_d = '0; tx_state_d = T_DATA; end
        T_DATA:  if (tx_bit_end) begin
                   tx_shift_d = {1'b0, tx_shift_q[7:1]};
                   tx_bit_d   = tx_bit_q + 3'd1;
                   if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
                 end
        T_STOP:  if (tx_bit_end) tx_state_d = T_IDLE;
      endcase
    end
  end

  // Moore output: reset forces IDLE asynchronously, so the line goes high immediately.
  always_comb begin
    tx_pop = !tx_empty && ((tx_state_q == T_IDLE) || ((tx_state_q == T_STOP) && tx_bit_end));
    unique case (tx_state_q)
      T_START: uart_tx = 1'b0;
      T_DATA:  uart_tx = tx_shift_q[0];
      default: uart_tx = 1'b1;
    endcase
  end

  // ---------------- RX engine ----------------
  logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1; end
    else        begin rx_s1_q <= uart_rx; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q; end
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_d;
  logic [DIV_W:0]   half_w;
  logic             rx_half_end, rx_bit_end, frm_set;

  assign half_w      = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
  assign rx_half_end = ({1'b0, rx_baud_q} + (DIV_W+1)'(1)) >= half_w;
  assign rx_bit_end  = (rx_baud_q >= div_q);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_state_q <= R_IDLE; rx_baud_q <= '0; rx_bit_q <= '0; rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d; rx_baud_q <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;   rx_shift_q <= rx_shift_d;
    end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_baud_d  = rx_baud_q + DIV_W'(1);
    case (rx_state_q)
      R_IDLE:  begin rx_baud_d = '0; if (rx_fall) rx_state_d = R_START; end
      R_START: if (rx_half_end) begin
                 rx_baud_d  = '0;
                 rx_bit_d   = '0;
                 rx_state_d = rx_s2_q ? R_IDLE : R_DATA;  // high at mid-start = glitch
               end
      R_DATA:  if (rx_bit_end) begin
                 rx_baud_d  = '0;
                 rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                 rx_bit_d   = rx_bit_q + 3'd1;
                 if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
               end
      R_STOP:  if (rx_bit_end) begin
                 rx_baud_d  = '0;
                 rx_state_d = rx_s2_q ? R_IDLE : R_BREAK;
               end
      R_BREAK: begin rx_baud_d = '0; if (rx_s2_q) rx_state_d = R_IDLE; end
      default: rx_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state_q == R_STOP) && rx_bit_end && rx_s2_q;
    frm_set = (rx_state_q == R_STOP) && rx_bit_end && !rx_s2_q;
  end

  // ---------------- sticky flags (event set wins over W1C) ----------------
  logic rx_ovr_q, frm_err_q, tx_ovf_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_ovr_q <= 1'b0; frm_err_q <= 1'b0; tx_ovf_q <= 1'b0;
    end else begin
      if (rx_push && rx_full)         rx_ovr_q  <= 1'b1;
      else if (stat_clr && data_i[5]) rx_ovr_q  <= 1'b0;
      if (frm_set)                    frm_err_q <= 1'b1;
      else if (stat_clr && data_i[6]) frm_err_q <= 1'b0;
      if (tx_push && tx_full)         tx_ovf_q  <= 1'b1;
      else if (stat_clr && data_i[7]) tx_ovf_q  <= 1'b0;
    end

  // ---------------- read mux and interrupt ----------------
  logic [7:0] status;
  assign status = {tx_ovf_q, frm_err_q, rx_ovr_q, tx_busy, tx_full, tx_empty, rx_full, ~rx_empty};

  always_comb begin
    data_o = 8'h00;
    case (reg_addr)
      A_DATA:   if (!rx_empty) data_o = rx_mem[rx_rp_q[AW-1:0]];
      A_STATUS: data_o = status;
      A_DIV_LO: data_o = div16[7:0];
      A_DIV_HI: data_o = div16[15:8];
      A_CTRL:   data_o = {6'b0, tx_ie_q, rx_ie_q};
      A_RX_CNT: data_o = 8'(rx_cnt);
      A_TX_CNT: data_o = 8'(tx_cnt);
      default:  data_o = 8'h00;
    endcase
  end

  logic irq_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= (rx_ie_q & ~rx_empty) | (tx_ie_q & ~tx_busy);
  assign irq = irq_q;

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed self-checking bench for uart_fifo (defaults, DIV set to 15 for serial tests).
module tb_uart_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_cs = 1'b0;
  logic       R_W_n = 1'b1;
  logic [2:0] reg_addr = 3'd0;
  logic [7:0] data_i = 8'h00;
  logic [7:0] data_o;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       irq;

  localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_DIV_LO = 3'd2, A_DIV_HI = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4, A_RX_CNT = 3'd5, A_TX_CNT = 3'd6, A_NONE = 3'd7;
  localparam int BIT_CLKS = 16;  // DIV = 15

  int n_checks = 0;
  int n_fail   = 0;

  uart_fifo dut (
    .clk(clk), .rst_n(rst_n), .uart_cs(uart_cs), .R_W_n(R_W_n), .reg_addr(reg_addr),
    .data_i(data_i), .data_o(data_o), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); reg_addr = a; data_i = d; R_W_n = 1'b0; uart_cs = 1'b1;
    @(negedge clk); uart_cs = 1'b0; R_W_n = 1'b1;
    @(negedge clk);
  endtask

  // Holds cs for hold_clks cycles; value is captured before the access edge.
  task automatic bus_read(input logic [2:0] a, input int hold_clks, output logic [7:0] d);
    @(negedge clk); reg_addr = a; R_W_n = 1'b1; uart_cs = 1'b1;
    #1 d = data_o;
    repeat (hold_clks) @(negedge clk);
    uart_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, 1, d);
    check(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk); uart_rx = 1'b0; repeat (BIT_CLKS-1) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); uart_rx = b[j]; repeat (BIT_CLKS-1) @(negedge clk);
    end
    @(negedge clk); uart_rx = stop; repeat (BIT_CLKS-1) @(negedge clk);
    if (!stop) begin
      @(negedge clk); uart_rx = 1'b1; repeat (4) @(negedge clk);
    end
  endtask

  logic [319:0] tx_got, tx_exp;
  logic [7:0]   tx_bytes [2];
  logic [7:0]   dec0, dec1, d;
  logic         found;

  initial begin
    // ---------- reset defaults ----------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_irq", irq, 1'b0);
    read_check("rst_status", A_STATUS, 8'h04);
    read_check("rst_div_lo", A_DIV_LO, 8'hD9);
    read_check("rst_div_hi", A_DIV_HI, 8'h00);
    read_check("rst_ctrl", A_CTRL, 8'h00);
    read_check("rst_rx_cnt", A_RX_CNT, 8'h00);
    read_check("rst_reg7", A_NONE, 8'h00);

    // ---------- DIV = 15, two back-to-back TX frames ----------
    bus_write(A_DIV_LO, 8'h0F);
    read_check("div_lo_15", A_DIV_LO, 8'h0F);
    tx_bytes[0] = 8'h55; tx_bytes[1] = 8'hA3;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 10; b++)
        for (int s = 0; s < BIT_CLKS; s++)
          tx_exp[f*160 + b*16 + s] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : tx_bytes[f][b-1];
    tx_got = '1;
    found  = 1'b0;
    fork
      begin bus_write(A_DATA, 8'h55); bus_write(A_DATA, 8'hA3); end
      begin
        for (int i = 0; i < 100 && !found; i++) begin
          @(negedge clk);
          if (uart_tx == 1'b0) found = 1'b1;
        end
        if (found) begin
          tx_got[0] = uart_tx;
          for (int i = 1; i < 320; i++) begin @(negedge clk); tx_got[i] = uart_tx; end
        end
      end
    join
    check("tx_start_seen", found, 1'b1);
    for (int j = 0; j < 8; j++) begin
      dec0[j] = tx_got[(j+1)*16 + 8];
      dec1[j] = tx_got[160 + (j+1)*16 + 8];
    end
    check("tx_byte0", dec0, 8'h55);
    check("tx_byte1", dec1, 8'hA3);
    check("tx_wave", tx_got, tx_exp);
    @(negedge clk);
    check("tx_idle_after", uart_tx, 1'b1);
    read_check("tx_done_status", A_STATUS, 8'h04);

    // ---------- RX 0x3C, then hold-read pops once ----------
    send_frame(8'h3C, 1'b1);
    read_check("rx_cnt_1", A_RX_CNT, 8'h01);
    read_check("rx_status_avail", A_STATUS, 8'h05);
    send_frame(8'h81, 1'b1);
    bus_read(A_DATA, 5, d);
    check("rx_data_3c", d, 8'h3C);
    read_check("rx_cnt_after_hold", A_RX_CNT, 8'h01);
    read_check("rx_data_81", A_DATA, 8'h81);
    read_check("rx_cnt_0", A_RX_CNT, 8'h00);
    read_check("rx_empty_read", A_DATA, 8'h00);

    // ---------- framing error and glitch ----------
    send_frame(8'h96, 1'b0);
    read_check("frm_err_status", A_STATUS, 8'h44);
    read_check("frm_rx_cnt", A_RX_CNT, 8'h00);
    @(negedge clk); uart_rx = 1'b0; repeat (3) @(negedge clk);
    @(negedge clk); uart_rx = 1'b1; repeat (40) @(negedge clk);
    read_check("glitch_rx_cnt", A_RX_CNT, 8'h00);
    read_check("glitch_status", A_STATUS, 8'h44);
    bus_write(A_STATUS, 8'h40);
    read_check("frm_err_clr", A_STATUS, 8'h04);

    // ---------- RX interrupt ----------
    bus_write(A_CTRL, 8'h01);
    check("irq_idle", irq, 1'b0);
    reg_addr = A_RX_CNT;
    found = 1'b0;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(negedge clk);
          if (data_o != 8'h00) found = 1'b1;
        end
        check("irq_push_seen", found, 1'b1);
        check("irq_at_push", irq, 1'b0);
        @(negedge clk);
        check("irq_push_plus1", irq, 1'b1);
      end
    join
    read_check("irq_data", A_DATA, 8'h5A);
    check("irq_after_pop", irq, 1'b0);
    bus_write(A_CTRL, 8'h00);

    // ---------- RX overrun ----------
    for (int i = 0; i < 17; i++) send_frame(8'(8'hA0 + i), 1'b1);
    read_check("rx_ovr_cnt", A_RX_CNT, 8'h10);
    read_check("rx_ovr_status", A_STATUS, 8'h27);
    for (int i = 0; i < 16; i++) read_check($sformatf("rx_ovr_byte%0d", i), A_DATA, 8'(8'hA0 + i));
    read_check("rx_ovr_drained", A_RX_CNT, 8'h00);
    bus_write(A_STATUS, 8'h20);
    read_check("rx_ovr_clr", A_STATUS, 8'h04);

    // ---------- TX overflow with a stalled frame, flush, reset mid-frame ----------
    bus_write(A_DIV_LO, 8'hFF);
    bus_write(A_DIV_HI, 8'hFF);
    bus_write(A_DATA, 8'h00);
    read_check("tx_stall_cnt0", A_TX_CNT, 8'h00);
    for (int i = 0; i < 17; i++) bus_write(A_DATA, 8'(i + 1));
    read_check("tx_ovf_cnt", A_TX_CNT, 8'h10);
    read_check("tx_ovf_status", A_STATUS, 8'h98);
    bus_write(A_STATUS, 8'h80);
    read_check("tx_ovf_clr", A_STATUS, 8'h18);
    bus_write(A_CTRL, 8'h08);
    read_check("tx_flush_cnt", A_TX_CNT, 8'h00);
    read_check("tx_flush_status", A_STATUS, 8'h14);
    read_check("tx_flush_ctrl", A_CTRL, 8'h00);
    check("tx_mid_frame_low", uart_tx, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_tx", uart_tx, 1'b1);
    #4 rst_n = 1'b1;
    @(negedge clk);
    read_check("post_rst_status", A_STATUS, 8'h04);
    read_check("post_rst_div_lo", A_DIV_LO, 8'hD9);
    read_check("post_rst_div_hi", A_DIV_HI, 8'h00);
    read_check("post_rst_tx_cnt", A_TX_CNT, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
